// File: rtl/pwm_deadtime.sv
// Registers the raw compare result and counts cycles since its last edge, so
// each output is held off for dead_time cycles after it turns on.
module pwm_deadtime (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw,
  input  logic [31:0] dead_time,
  output logic        hi,
  output logic        lo
);

  logic        raw_q;
  logic        raw_d;
  logic [31:0] dt_q;
  logic [31:0] dt_d;
  logic        dt_ok_s;

  // Next state: restart the dead-time count on every edge of raw_q, else saturating count.
  always_comb begin
    raw_d = raw;
    dt_d  = dt_q;
    if (raw != raw_q) begin
      dt_d = 32'd0;
    end else if (dt_q == 32'hFFFF_FFFF) begin
      dt_d = dt_q;
    end else begin
      dt_d = dt_q + 32'd1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= 1'b0;
      dt_q  <= 32'd0;
    end else begin
      raw_q <= raw_d;
      dt_q  <= dt_d;
    end
  end

  assign dt_ok_s = (dt_q >= dead_time);
  assign hi      = raw_q & dt_ok_s;
  assign lo      = ~raw_q & dt_ok_s;

endmodule

// File: rtl/pwm_unit.sv
// Edge-aligned PWM with complementary dead-time output and counter-wrap trigger.
// Period and duty are shadowed so mid-period writes apply at the next wrap.
module pwm_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] period,
  input  logic [31:0] duty,
  input  logic [31:0] dead_time,
  input  logic        pwm_enable,
  input  logic        ovf_trigger_enable,
  output logic        pwm,
  output logic        pwm_cmp,
  output logic        ovf_trigger
);

  logic [31:0] period_sh_q;
  logic [31:0] period_sh_d;
  logic [31:0] duty_sh_q;
  logic [31:0] duty_sh_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        wrap_q;
  logic        wrap_s;
  logic        raw_s;
  logic        hi_s;
  logic        lo_s;

  // Period of 0 or 1 pins the counter at 0 and wraps every cycle.
  assign wrap_s = (period_sh_q <= 32'd1) || (cnt_q >= (period_sh_q - 32'd1));
  assign raw_s  = (cnt_q < duty_sh_q);

  // Next state for the counter and shadow registers.
  always_comb begin
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    if (wrap_s) begin
      cnt_d       = 32'd0;
      period_sh_d = period;
      duty_sh_d   = duty;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State register; shadows track the inputs while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_sh_q <= period;
      duty_sh_q   <= duty;
      cnt_q       <= 32'd0;
      wrap_q      <= 1'b0;
    end else begin
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_s;
    end
  end

  pwm_deadtime u_deadtime (
    .clk       (clk),
    .reset     (reset),
    .raw       (raw_s),
    .dead_time (dead_time),
    .hi        (hi_s),
    .lo        (lo_s)
  );

  assign pwm         = pwm_enable & ~reset & hi_s;
  assign pwm_cmp     = pwm_enable & ~reset & lo_s;
  assign ovf_trigger = ovf_trigger_enable & ~reset & wrap_q;

endmodule

// File: tb/tb_pwm_unit.sv
// Self-checking bench for pwm_unit: steady-state width table, hand-written
// corner sequences, then randomized traffic against a cycle reference model.
module tb_pwm_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] period;
  logic [31:0] duty;
  logic [31:0] dead_time;
  logic        pwm_enable;
  logic        ovf_trigger_enable;
  logic        pwm;
  logic        pwm_cmp;
  logic        ovf_trigger;

  int checks = 0;
  int failures = 0;

  pwm_unit dut (
    .clk                (clk),
    .reset              (reset),
    .period             (period),
    .duty               (duty),
    .dead_time          (dead_time),
    .pwm_enable         (pwm_enable),
    .ovf_trigger_enable (ovf_trigger_enable),
    .pwm                (pwm),
    .pwm_cmp            (pwm_cmp),
    .ovf_trigger        (ovf_trigger)
  );

  always #5 clk = ~clk;

  // Reference model: counter position within the period, latched shadows,
  // previous compare result and how long it has been stable.
  longint m_psh, m_dsh, m_pos, m_run;
  bit     m_rawq, m_wrapq;

  task automatic model_step();
    bit     raw;
    longint nxt;
    if (reset) begin
      m_psh = period; m_dsh = duty; m_pos = 0; m_run = 0;
      m_rawq = 0; m_wrapq = 0;
    end else begin
      raw = (m_pos < m_dsh);
      nxt = (m_psh < 2) ? 0 : (m_pos + 1) % m_psh;
      m_wrapq = (nxt == 0);
      if (m_wrapq) begin
        m_psh = period;
        m_dsh = duty;
      end
      if (raw == m_rawq) m_run = (m_run + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_run + 1;
      else m_run = 0;
      m_rawq = raw;
      m_pos = nxt;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts output highs over 10 samples; optionally writes a new duty mid-window.
  task automatic count_win(input int change_at, input logic [31:0] new_duty,
                           output int np, output int nc, output int no);
    np = 0; nc = 0; no = 0;
    for (int k = 0; k < 10; k++) begin
      np += int'(pwm); nc += int'(pwm_cmp); no += int'(ovf_trigger);
      if (k == change_at) duty = new_duty;
      tick();
    end
  endtask

  task automatic start(input logic [31:0] p, input logic [31:0] d, input logic [31:0] t);
    reset = 1'b1; period = p; duty = d; dead_time = t;
    pwm_enable = 1'b1; ovf_trigger_enable = 1'b1;
    for (int k = 0; k < 21; k++) tick();
    reset = 1'b0;
    for (int k = 0; k < 30; k++) tick();
  endtask

  task automatic sync_ovf();
    int n = 0;
    while (ovf_trigger !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("sync_ovf_seen", int'(ovf_trigger), 1);
  endtask

  typedef struct {
    logic [31:0] per;
    logic [31:0] dut;
    logic [31:0] dtm;
    int          e_pwm;
    int          e_cmp;
    int          e_ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int np, nc, no, n;
    tbl[0] = '{32'd10, 32'd2,   32'd1, 1,  7,  1};
    tbl[1] = '{32'd10, 32'd3,   32'd1, 2,  6,  1};
    tbl[2] = '{32'd10, 32'd0,   32'd1, 0,  10, 1};
    tbl[3] = '{32'd10, 32'd500, 32'd1, 10, 0,  1};
    tbl[4] = '{32'd10, 32'd8,   32'd1, 7,  1,  1};
    tbl[5] = '{32'd10, 32'd5,   32'd0, 5,  5,  1};
    tbl[6] = '{32'd10, 32'd2,   32'd5, 0,  3,  1};
    tbl[7] = '{32'd1,  32'd0,   32'd0, 0,  10, 10};
    tbl[8] = '{32'd0,  32'd3,   32'd0, 10, 0,  10};

    reset = 1'b1; period = 32'd10; duty = 32'd2; dead_time = 32'd1;
    pwm_enable = 1'b1; ovf_trigger_enable = 1'b1;
    tick();
    chk("reset_outputs", {pwm, pwm_cmp, ovf_trigger}, 0);

    for (int i = 0; i < 9; i++) begin
      start(tbl[i].per, tbl[i].dut, tbl[i].dtm);
      count_win(-1, 32'd0, np, nc, no);
      chk($sformatf("tbl%0d_pwm", i), np, tbl[i].e_pwm);
      chk($sformatf("tbl%0d_cmp", i), nc, tbl[i].e_cmp);
      chk($sformatf("tbl%0d_ovf", i), no, tbl[i].e_ovf);
    end

    // Mid-period duty change applies only from the next wrap.
    start(32'd10, 32'd2, 32'd1);
    sync_ovf();
    count_win(4, 32'd3, np, nc, no);
    chk("dchg_old_pwm", np, 1);
    chk("dchg_old_cmp", nc, 7);
    chk("dchg_aligned", int'(ovf_trigger), 1);
    count_win(-1, 32'd0, np, nc, no);
    chk("dchg_new_pwm", np, 2);
    chk("dchg_new_cmp", nc, 6);

    // Disabling forces outputs low while the counter keeps its phase.
    start(32'd10, 32'd8, 32'd1);
    sync_ovf();
    count_win(-1, 32'd0, np, nc, no);
    chk("dis_pre_pwm", np, 7);
    chk("dis_pre_cmp", nc, 1);
    for (int k = 0; k < 3; k++) tick();
    pwm_enable = 1'b0; ovf_trigger_enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("dis_outputs_low", {pwm, pwm_cmp, ovf_trigger}, 0);
    end
    pwm_enable = 1'b1; ovf_trigger_enable = 1'b1;
    n = 0;
    while (ovf_trigger !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("dis_phase_kept", n, 7);

    // Reset mid-period, then restart from 0 with no dead time.
    start(32'd10, 32'd2, 32'd0);
    sync_ovf();
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    chk("rst_outputs_low", {pwm, pwm_cmp, ovf_trigger}, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_rel_pwm", int'(pwm), 0);
    chk("rst_rel_cmp", int'(pwm_cmp), 1);
    tick();
    chk("rst_first_rise", int'(pwm), 1);
    n = 1;
    while (ovf_trigger !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("rst_first_ovf", n, 10);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) period = $urandom_range(16);
      if ($urandom_range(19) == 0) duty = $urandom_range(20);
      if ($urandom_range(29) == 0) dead_time = $urandom_range(5);
      if ($urandom_range(299) == 0) dead_time = 32'hFFFF_FFFF;
      if ($urandom_range(39) == 0) pwm_enable = ~pwm_enable;
      if ($urandom_range(39) == 0) ovf_trigger_enable = ~ovf_trigger_enable;
      tick();
      chk("rand_outputs", {pwm, pwm_cmp, ovf_trigger},
          {pwm_enable & ~reset & m_rawq & (m_run >= longint'(dead_time)),
           pwm_enable & ~reset & ~m_rawq & (m_run >= longint'(dead_time)),
           ovf_trigger_enable & ~reset & m_wrapq});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
